// File: rtl/key_pkg.sv
// ============================================================================
// Module      : key_pkg
// Description : Shared timing constants and helpers for the key debouncers.
//               Optional feature macro: KEY_DEBOUNCE_REPEAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package key_pkg;

    // 25 MHz system clock
    localparam int CNT_MAX_80MS     = 2000000;
    localparam int LONG_CNT_1S      = 25000000;
    localparam int REPEAT_CNT_200MS = 5000000;

    // Bits needed to index 0..value-1, never less than one bit.
    function automatic int clog2(input int unsigned value);
        int unsigned v;
        int          w;
        v = (value > 1) ? value - 1 : 1;
        w = 0;
        while (v != 0) begin
            v = v >> 1;
            w++;
        end
        return w;
    endfunction

    // Pin level of a released key.
    function automatic logic key_idle(input int active_low);
        return (active_low != 0) ? 1'b1 : 1'b0;
    endfunction

endpackage : key_pkg

`default_nettype wire

// File: rtl/key_debounce_ch.sv
// ============================================================================
// Module      : key_debounce_ch
// Description : One key channel: 2-flop synchroniser, stability counter,
//               press/release/long-press strobes. KEY_DEBOUNCE_REPEAT_EN
//               adds auto-repeat.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_debounce_ch
    import key_pkg::*;
#(
    parameter int CNT_MAX    = CNT_MAX_80MS,
    parameter int LONG_CNT   = LONG_CNT_1S,
`ifdef KEY_DEBOUNCE_REPEAT_EN
    parameter int REPEAT_CNT = REPEAT_CNT_200MS,
`endif
    parameter int ACTIVE_LOW = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic key_in,
    output logic key_out,
    output logic key_press,
    output logic key_release,
`ifdef KEY_DEBOUNCE_REPEAT_EN
    output logic key_repeat,
`endif
    output logic key_long
);

    localparam logic c_idle   = key_idle(ACTIVE_LOW);
    localparam int   c_stab_w = clog2(CNT_MAX + 1);
    localparam int   c_hold_w = clog2(LONG_CNT + 1);

    localparam logic [c_stab_w-1:0] c_stab_max = c_stab_w'(CNT_MAX);
    localparam logic [c_hold_w-1:0] c_hold_max = c_hold_w'(LONG_CNT);
    localparam logic [c_hold_w-1:0] c_hold_pre = c_hold_w'(LONG_CNT - 1);

    logic                r_sync0;
    logic                r_sync1;
    logic [c_stab_w-1:0] r_stab_cnt;
    logic [c_hold_w-1:0] r_hold_cnt;
    logic                r_key_out;
    logic                r_press;
    logic                r_release;
    logic                r_long;

    logic w_mismatch;
    logic w_accept;
    logic w_pressed;
    logic w_press;
    logic w_release;
    logic w_holding;

    assign w_mismatch = (r_sync1 != r_key_out);
    assign w_accept   = w_mismatch && (r_stab_cnt == c_stab_max);
    assign w_pressed  = (r_key_out != c_idle);
    assign w_press    = w_accept && !w_pressed;
    assign w_release  = w_accept && w_pressed;
    // Hold time runs only while pressed and not being released this edge.
    assign w_holding  = w_pressed && !w_release;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync0    <= c_idle;
            r_sync1    <= c_idle;
            r_stab_cnt <= '0;
            r_hold_cnt <= '0;
            r_key_out  <= c_idle;
            r_press    <= 1'b0;
            r_release  <= 1'b0;
            r_long     <= 1'b0;
        end else begin
            r_sync0 <= key_in;
            r_sync1 <= r_sync0;

            if (!w_mismatch) begin
                r_stab_cnt <= '0;
            end else if (w_accept) begin
                r_key_out  <= r_sync1;
                r_stab_cnt <= '0;
            end else begin
                r_stab_cnt <= r_stab_cnt + 1'b1;
            end

            r_press   <= w_press;
            r_release <= w_release;

            if (!w_holding) begin
                r_hold_cnt <= '0;
            end else if (r_hold_cnt != c_hold_max) begin
                r_hold_cnt <= r_hold_cnt + 1'b1;
            end

            r_long <= w_holding && (r_hold_cnt == c_hold_pre);
        end
    end

`ifdef KEY_DEBOUNCE_REPEAT_EN
    localparam int                 c_rep_w    = clog2(REPEAT_CNT);
    localparam logic [c_rep_w-1:0] c_rep_last = c_rep_w'(REPEAT_CNT - 1);

    logic [c_rep_w-1:0] r_rep_cnt;
    logic               r_repeat;
    logic               w_rep_run;

    // Repeat phase starts the cycle after key_long, i.e. once hold saturates.
    assign w_rep_run = w_holding && (r_hold_cnt == c_hold_max);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rep_cnt <= '0;
            r_repeat  <= 1'b0;
        end else begin
            if (!w_rep_run || (r_rep_cnt == c_rep_last)) begin
                r_rep_cnt <= '0;
            end else begin
                r_rep_cnt <= r_rep_cnt + 1'b1;
            end
            r_repeat <= w_rep_run && (r_rep_cnt == c_rep_last);
        end
    end

    assign key_repeat = r_repeat;
`endif

    assign key_out     = r_key_out;
    assign key_press   = r_press;
    assign key_release = r_release;
    assign key_long    = r_long;

endmodule : key_debounce_ch

`default_nettype wire

// File: rtl/key_debounce_multi.sv
// ============================================================================
// Module      : key_debounce_multi
// Description : N-channel push-button debouncer with press/release/long-press
//               strobes. KEY_DEBOUNCE_REPEAT_EN adds key_repeat.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_debounce_multi
    import key_pkg::*;
#(
    parameter int N_KEYS     = 4,
    parameter int CNT_MAX    = CNT_MAX_80MS,
    parameter int LONG_CNT   = LONG_CNT_1S,
`ifdef KEY_DEBOUNCE_REPEAT_EN
    parameter int REPEAT_CNT = REPEAT_CNT_200MS,
`endif
    parameter int ACTIVE_LOW = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] key_in,
    output logic [N_KEYS-1:0] key_out,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
`ifdef KEY_DEBOUNCE_REPEAT_EN
    output logic [N_KEYS-1:0] key_repeat,
`endif
    output logic [N_KEYS-1:0] key_long
);

    for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
        key_debounce_ch #(
            .CNT_MAX    (CNT_MAX),
            .LONG_CNT   (LONG_CNT),
`ifdef KEY_DEBOUNCE_REPEAT_EN
            .REPEAT_CNT (REPEAT_CNT),
`endif
            .ACTIVE_LOW (ACTIVE_LOW)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .key_in      (key_in[g]),
            .key_out     (key_out[g]),
            .key_press   (key_press[g]),
            .key_release (key_release[g]),
`ifdef KEY_DEBOUNCE_REPEAT_EN
            .key_repeat  (key_repeat[g]),
`endif
            .key_long    (key_long[g])
        );
    end : g_ch

endmodule : key_debounce_multi

`default_nettype wire

// File: tb/tb_key_debounce_multi.sv
// ============================================================================
// Module      : tb_key_debounce_multi
// Description : Directed self-checking bench for key_debounce_multi
//               (CNT_MAX=4, LONG_CNT=20; REPEAT_CNT=8 with KEY_DEBOUNCE_REPEAT_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_key_debounce_multi;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] key_in;
    logic [N-1:0] key_out;
    logic [N-1:0] key_press;
    logic [N-1:0] key_release;
    logic [N-1:0] key_long;
`ifdef KEY_DEBOUNCE_REPEAT_EN
    logic [N-1:0] key_repeat;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    key_debounce_multi #(
        .N_KEYS     (N),
        .CNT_MAX    (4),
        .LONG_CNT   (20),
`ifdef KEY_DEBOUNCE_REPEAT_EN
        .REPEAT_CNT (8),
`endif
        .ACTIVE_LOW (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_in      (key_in),
        .key_out     (key_out),
        .key_press   (key_press),
        .key_release (key_release),
`ifdef KEY_DEBOUNCE_REPEAT_EN
        .key_repeat  (key_repeat),
`endif
        .key_long    (key_long)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_strobes(input string tag);
        chk({tag, " press"}, key_press, 4'b0000);
        chk({tag, " release"}, key_release, 4'b0000);
    endtask

    logic [N-1:0] acc;

    initial begin
        // Reset for two cycles
        rst    = 1'b1;
        key_in = 4'b1111;
        tick();
        chk("rst key_out", key_out, 4'b1111);
        chk_idle_strobes("rst");
        chk("rst long", key_long, 4'b0000);
        tick();
        rst = 1'b0;
        acc = '0;
        for (int i = 0; i < 20; i++) begin
            tick();
            acc = acc | key_press | key_release | key_long | ~key_out;
        end
        chk("post-rst quiet", acc, 4'b0000);

        // Clean press on key 0: change lands on edge 7
        key_in[0] = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            chk("k0 press wait key_out", key_out, 4'b1111);
            chk("k0 press wait strobe", key_press, 4'b0000);
        end
        tick();
        chk("k0 press key_out", key_out, 4'b1110);
        chk("k0 press strobe", key_press, 4'b0001);
        chk("k0 press no release", key_release, 4'b0000);
        tick();
        chk("k0 press one cycle", key_press, 4'b0000);
        chk("k0 held key_out", key_out, 4'b1110);

        // Release key 0
        key_in[0] = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            chk("k0 rel wait key_out", key_out, 4'b1110);
        end
        tick();
        chk("k0 rel key_out", key_out, 4'b1111);
        chk("k0 rel strobe", key_release, 4'b0001);
        chk("k0 rel no press", key_press, 4'b0000);
        tick();
        chk("k0 rel one cycle", key_release, 4'b0000);

        // Bounce on key 1: low 3, high 1, then low held
        key_in[1] = 1'b0;
        tick(); tick(); tick();
        key_in[1] = 1'b1;
        tick();
        key_in[1] = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            chk("k1 bounce wait key_out", key_out, 4'b1111);
        end
        tick();
        chk("k1 bounce key_out", key_out, 4'b1101);
        chk("k1 bounce press", key_press, 4'b0010);
        key_in[1] = 1'b1;
        for (int i = 1; i <= 6; i++) tick();
        chk("k1 rel pre key_out", key_out, 4'b1101);
        tick();
        chk("k1 rel strobe", key_release, 4'b0010);
        chk("k1 rel key_out", key_out, 4'b1111);

        // A 4-cycle low pulse reaches CNT_MAX but is never accepted
        key_in[1] = 1'b0;
        tick(); tick(); tick(); tick();
        key_in[1] = 1'b1;
        acc = '0;
        for (int i = 0; i < 12; i++) begin
            tick();
            acc = acc | key_press | key_release | ~key_out;
        end
        chk("k1 short pulse rejected", acc, 4'b0000);

        // Long press on key 2
        key_in[2] = 1'b0;
        for (int i = 1; i <= 7; i++) tick();
        chk("k2 press", key_press, 4'b0100);
        acc = '0;
        for (int i = 1; i <= 19; i++) begin
            tick();
            acc = acc | key_long;
        end
        chk("k2 no early long", acc, 4'b0000);
        tick();
        chk("k2 long at +20", key_long, 4'b0100);
        acc = '0;
        for (int i = 0; i < 100; i++) begin
            tick();
            acc = acc | key_long | key_press | key_release;
        end
        chk("k2 long once", acc, 4'b0000);
        chk("k2 still held", key_out, 4'b1011);
        key_in[2] = 1'b1;
        for (int i = 1; i <= 7; i++) tick();
        chk("k2 release", key_release, 4'b0100);

        // Re-press key 2: long fires again
        key_in[2] = 1'b0;
        for (int i = 1; i <= 7; i++) tick();
        chk("k2 re-press", key_press, 4'b0100);
        for (int i = 1; i <= 19; i++) tick();
        chk("k2 re long not yet", key_long, 4'b0000);
        tick();
        chk("k2 re long", key_long, 4'b0100);
`ifdef KEY_DEBOUNCE_REPEAT_EN
        chk("k2 no repeat at long", key_repeat, 4'b0000);
        for (int k = 1; k <= 25; k++) begin
            tick();
            chk("k2 repeat", key_repeat, (k % 8 == 0) ? 4'b0100 : 4'b0000);
        end
        // Debounced release lands on the edge where the 4th repeat would be
        key_in[2] = 1'b1;
        for (int j = 1; j <= 7; j++) begin
            tick();
            chk("k2 repeat during release", key_repeat, 4'b0000);
        end
        chk("k2 rep release strobe", key_release, 4'b0100);
        acc = '0;
        for (int i = 0; i < 20; i++) begin
            tick();
            acc = acc | key_repeat;
        end
        chk("k2 repeat stopped", acc, 4'b0000);
`else
        key_in[2] = 1'b1;
        for (int i = 1; i <= 7; i++) tick();
        chk("k2 re release", key_release, 4'b0100);
`endif
        tick();

        // Keys 0 and 3 together
        key_in = 4'b0110;
        for (int i = 1; i <= 6; i++) tick();
        chk("k03 wait", key_press, 4'b0000);
        tick();
        chk("k03 press", key_press, 4'b1001);
        chk("k03 key_out", key_out, 4'b0110);
        key_in = 4'b1111;
        for (int i = 1; i <= 7; i++) tick();
        chk("k03 release", key_release, 4'b1001);
        chk("k03 rel key_out", key_out, 4'b1111);
        tick();

        // Reset while key 3 is mid-count
        key_in[3] = 1'b0;
        tick(); tick(); tick(); tick();
        rst = 1'b1;
        tick();
        chk("mid rst key_out", key_out, 4'b1111);
        chk_idle_strobes("mid rst");
        rst = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            chk("k3 restart wait", key_out, 4'b1111);
            chk_idle_strobes("k3 restart wait");
        end
        tick();
        chk("k3 restart key_out", key_out, 4'b0111);
        chk("k3 restart press", key_press, 4'b1000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_key_debounce_multi

`default_nettype wire
